fp_unpack_norm: RTL and testbench

- Input-side unpack stage for the IEEE-754 single-precision Sin/Cos datapath; it is the decode counterpart to the output-side special-case/result packer.
- Accepts one 32-bit operand per transaction and classifies it as zero, inf, NaN, denormal or normal.
- Emits sign, unbiased signed exponent and a 24-bit mantissa with explicit hidden bit. Denormals are normalised by an iterative left-shift FSM.
- Valid/ready handshakes on both sides; one operand in flight at a time.

---
 rtl/fp_unpack_norm_if.sv | 38 +++
 rtl/fp_unpack_norm.sv | 188 ++++++++++++++++++
 tb/tb_fp_unpack_norm.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_unpack_norm_if.sv
// ---------------------------------------------------------------------------
// fp_unpack_norm_if
// Handshake/data bundle for the single-precision unpack stage.
//   Input side  : in_valid / in_ready / in_data[31:0]  (raw IEEE-754 operand)
//   Output side : out_valid / out_ready plus the unpacked fields
//                 out_sign, out_exp[9:0] (signed, unbiased),
//                 out_mant[23:0] (bit 23 = hidden bit) and the class flags
//                 out_zero / out_inf / out_nan / out_denorm.
// Modports:
//   slave  - the unpack block (consumes operands, produces results)
//   master - the environment (upstream producer + downstream consumer)
// ---------------------------------------------------------------------------
interface fp_unpack_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [23:0] out_mant;
    logic        out_zero;
    logic        out_inf;
    logic        out_nan;
    logic        out_denorm;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant,
               out_zero, out_inf, out_nan, out_denorm
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant,
               out_zero, out_inf, out_nan, out_denorm
    );
endinterface

// File: rtl/fp_unpack_norm.sv
// ---------------------------------------------------------------------------
// fp_unpack_norm
// Decodes one IEEE-754 single-precision operand into sign, unbiased signed
// exponent and a 24-bit mantissa with explicit hidden bit, and classifies it
// as zero / inf / NaN / denormal / normal. Denormals are normalised by an
// iterative left shifter (SHIFT_PER_CYC bits per cycle, never overshooting).
// One operand in flight: IDLE accepts, NORM shifts, DONE holds the result
// until the downstream takes it.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (aborts any operand in flight)
//   bus  - fp_unpack_norm_if.slave (in_* operand handshake, out_* result)
//
// Parameters:
//   EXP_BIAS      - bias removed from the exponent field (127)
//   SHIFT_PER_CYC - mantissa bits shifted per NORM cycle; legal 1, 2, 4
//
// Build option:
//   FP_UNPACK_DAZ_EN - denormals-are-zero. A denormal is reported as a signed
//                      zero with out_denorm=1 after one cycle; the NORM state
//                      and the shifter are not built.
// ---------------------------------------------------------------------------
module fp_unpack_norm #(
    parameter int EXP_BIAS      = 127,
    parameter int SHIFT_PER_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    fp_unpack_norm_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifndef FP_UNPACK_DAZ_EN
        S_NORM = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

    // Inf/NaN report the exponent one past the largest normal one.
    localparam logic [9:0] EXP_SPECIAL = 10'd128;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;
    logic [23:0] mant_q, mant_d;
    logic        zero_q, zero_d;
    logic        inf_q, inf_d;
    logic        nan_q, nan_d;
    logic        denorm_q, denorm_d;

    logic [7:0]  exp_field;
    logic [22:0] frac_field;

    assign exp_field  = bus.in_data[30:23];
    assign frac_field = bus.in_data[22:0];

`ifndef FP_UNPACK_DAZ_EN
    // Denormals carry the minimum normal exponent before shifting.
    localparam logic [9:0] EXP_DENORM = 10'(1 - EXP_BIAS);

    // lead_hit[gi] is set when a 1 sits gi+1 places below the hidden-bit
    // position, i.e. shifting gi+1 bits would complete normalisation.
    logic [SHIFT_PER_CYC-1:0] lead_hit;
    logic [2:0]               shift_amt;
    logic [23:0]              mant_shifted;

    genvar gi;
    generate
        for (gi = 0; gi < SHIFT_PER_CYC; gi++) begin : g_lead
            assign lead_hit[gi] = mant_q[22-gi];
        end
    endgenerate

    // Smallest distance to a set bit within this cycle's window wins, so the
    // last step shifts only the remaining leading zeros. When the window is
    // all zero a full SHIFT_PER_CYC step is taken.
    always_comb begin
        shift_amt = 3'(SHIFT_PER_CYC);
        for (int i = SHIFT_PER_CYC - 1; i >= 0; i--) begin
            if (lead_hit[i]) begin
                shift_amt = 3'(i + 1);
            end
        end
        mant_shifted = mant_q << shift_amt;
    end
`endif

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        zero_d   = zero_q;
        inf_d    = inf_q;
        nan_d    = nan_q;
        denorm_d = denorm_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = bus.in_data[31];
                    zero_d   = 1'b0;
                    inf_d    = 1'b0;
                    nan_d    = 1'b0;
                    denorm_d = 1'b0;
                    state_d  = S_DONE;
                    if (exp_field == 8'h00 && frac_field == 23'd0) begin
                        exp_d  = 10'd0;
                        mant_d = 24'd0;
                        zero_d = 1'b1;
                    end else if (exp_field == 8'hFF) begin
                        // Inf gives {1,0} = 0x800000, NaN keeps its payload.
                        exp_d  = EXP_SPECIAL;
                        mant_d = {1'b1, frac_field};
                        inf_d  = (frac_field == 23'd0);
                        nan_d  = (frac_field != 23'd0);
                    end else if (exp_field == 8'h00) begin
                        denorm_d = 1'b1;
`ifdef FP_UNPACK_DAZ_EN
                        exp_d    = 10'd0;
                        mant_d   = 24'd0;
                        zero_d   = 1'b1;
`else
                        exp_d    = EXP_DENORM;
                        mant_d   = {1'b0, frac_field};
                        state_d  = S_NORM;
`endif
                    end else begin
                        exp_d  = {2'b00, exp_field} - 10'(EXP_BIAS);
                        mant_d = {1'b1, frac_field};
                    end
                end
            end
`ifndef FP_UNPACK_DAZ_EN
            S_NORM: begin
                mant_d = mant_shifted;
                exp_d  = exp_q - {7'd0, shift_amt};
                if (mant_shifted[23]) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= 10'd0;
            mant_q   <= 24'd0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            zero_q   <= zero_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
            denorm_q <= denorm_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_sign   = sign_q;
    assign bus.out_exp    = exp_q;
    assign bus.out_mant   = mant_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_inf    = inf_q;
    assign bus.out_nan    = nan_q;
    assign bus.out_denorm = denorm_q;

endmodule

// File: tb/tb_fp_unpack_norm.sv
// ---------------------------------------------------------------------------
// tb_fp_unpack_norm
// Self-checking bench for fp_unpack_norm. Expected results come from an
// arithmetic decode of the IEEE-754 fields (model()); a single compare
// process checks every cycle against the queue of accepted operands,
// including latency, hold stability and in_ready behaviour.
// ---------------------------------------------------------------------------
module tb_fp_unpack_norm;

    localparam int SPC  = 1;
    localparam int BIAS = 127;

    typedef struct {
        logic        sign;
        int          exp;
        logic [23:0] mant;
        logic        zero;
        logic        inf;
        logic        nan;
        logic        denorm;
        int          lat;
        int          acc_cyc;
        bit          seen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_unpack_norm_if bus();

    fp_unpack_norm #(.EXP_BIAS(BIAS), .SHIFT_PER_CYC(SPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Decode straight from the number-format rules.
    function automatic exp_t model(input logic [31:0] d);
        exp_t r;
        int e, p, k;
        logic [22:0] f;
        e = int'(d[30:23]);
        f = d[22:0];
        r.sign = d[31]; r.exp = 0; r.mant = 24'd0;
        r.zero = 0; r.inf = 0; r.nan = 0; r.denorm = 0;
        r.lat = 1; r.acc_cyc = 0; r.seen = 0;
        if (e == 0 && f == 0) begin
            r.zero = 1;
        end else if (e == 255) begin
            r.exp  = 128;
            r.mant = (f == 0) ? 24'h800000 : {1'b1, f};
            r.inf  = (f == 0);
            r.nan  = (f != 0);
        end else if (e == 0) begin
            r.denorm = 1;
`ifdef FP_UNPACK_DAZ_EN
            r.zero = 1;
`else
            p = 0;
            for (int i = 0; i < 23; i++) if (f[i]) p = i;
            k      = 23 - p;
            r.mant = {1'b0, f} << k;
            r.exp  = 1 - BIAS - k;
            r.lat  = 1 + (k + SPC - 1) / SPC;
`endif
        end else begin
            r.exp  = e - BIAS;
            r.mant = {1'b1, f};
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: runs on every falling edge.
    initial forever begin
        exp_t m;
        @(negedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    if (!q[0].seen) begin
                        chk("latency", cyc - q[0].acc_cyc, q[0].lat);
                        q[0].seen = 1;
                    end
                    chk("sign",     bus.out_sign,              q[0].sign);
                    chk("exp",      int'($signed(bus.out_exp)), q[0].exp);
                    chk("mant",     bus.out_mant,              q[0].mant);
                    chk("zero",     bus.out_zero,              q[0].zero);
                    chk("inf",      bus.out_inf,               q[0].inf);
                    chk("nan",      bus.out_nan,               q[0].nan);
                    chk("denorm",   bus.out_denorm,            q[0].denorm);
                    chk("done_in_ready", bus.in_ready, 0);
                    if (bus.out_ready) void'(q.pop_front());
                end
            end else if (q.size() != 0) begin
                chk("busy_in_ready", bus.in_ready, 0);
            end else begin
                chk("idle_in_ready", bus.in_ready, 1);
            end
            if (bus.in_valid && bus.in_ready) begin
                m = model(bus.in_data);
                m.acc_cyc = cyc;
                q.push_back(m);
            end
        end
    end

    // hold = cycles the result is held with out_ready=0 (0 = ready preset).
    task automatic do_op(input logic [31:0] d, input int hold);
        int n;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin n++; @(negedge clk); end
        chk("accept", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 60) begin n++; @(negedge clk); end
        chk("result_arrives", bus.out_valid, 1);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 bus.out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] f;
        logic        s;
        int          sh;
        s = 1'($urandom);
        f = $urandom;
        case ($urandom_range(0, 4))
            0: return {s, 31'd0};
            1: return {s, 8'hFF, 23'd0};
            2: begin
                if (f[22:0] == 23'd0) f = 32'd1;
                return {s, 8'hFF, f[22:0]};
            end
            3: begin
                sh = $urandom_range(0, 22);
                f  = (32'd1 << sh) | (f & ((32'd1 << sh) - 32'd1));
                return {s, 8'h00, f[22:0]};
            end
            default: return {s, 8'($urandom_range(1, 254)), f[22:0]};
        endcase
    endfunction

    initial begin
        exp_t r;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;

        // Hand-derived values that pin the model.
        r = model(32'h3F800000);
        chk("pin_one_exp", r.exp, 0);
        chk("pin_one_mant", r.mant, 24'h800000);
        r = model(32'hFF800000);
        chk("pin_ninf_exp", r.exp, 128);
        chk("pin_ninf_flag", r.inf, 1);
        r = model(32'h7FC00001);
        chk("pin_nan_mant", r.mant, 24'hC00001);
`ifdef FP_UNPACK_DAZ_EN
        r = model(32'h80000005);
        chk("pin_daz_zero", r.zero, 1);
        chk("pin_daz_lat", r.lat, 1);
`else
        r = model(32'h00000001);
        chk("pin_min_denorm_exp", r.exp, -149);
        chk("pin_min_denorm_lat", r.lat, 24);
        r = model(32'h00400000);
        chk("pin_denorm_exp", r.exp, -127);
        chk("pin_denorm_lat", r.lat, 2);
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_mant", bus.out_mant, 0);
        chk("rst_out_exp", bus.out_exp, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed operands.
        do_op(32'h3F800000, 0);
        do_op(32'h80000000, 0);
        do_op(32'hFF800000, 1);
        do_op(32'h7FC00001, 5);
        do_op(32'h00000001, 0);
        do_op(32'h00400000, 2);
        do_op(32'h80000005, 0);

        // Reset while a denormal is being normalised.
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h00000001;
        @(negedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_mant", bus.out_mant, 0);
        chk("abort_exp", bus.out_exp, 0);
        chk("abort_denorm", bus.out_denorm, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_abort_in_ready", bus.in_ready, 1);
        do_op(32'h40000000, 0);

        // Randomised operands and back-pressure.
        for (int i = 0; i < 60; i++) begin
            do_op(rand_operand(), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 50000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
